hex_marquee: RTL and testbench

- Upstream feeder for the six-digit 7-segment word display on the DE0-CV top level.
- Takes a message of MSG_LEN pre-encoded active-low segment characters and drives HEX5..HEX0 with a 6-character window that scrolls left at a fixed rate.
- Two debounced board keys control it: one toggles run/pause, the other single-steps the window while paused.
- Replaces the static KEY[0] word select with a timed, stateful source.

---
 rtl/hex_marquee.sv | 127 ++++++++++++
 tb/tb_hex_marquee.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/hex_marquee.sv
// Scrolls a MSG_LEN-character 7-segment message across hex5..hex0; outputs lag pos by one cycle.
// Key presses act 2+DEBOUNCE_CYCLES cycles after the raw edge; no backpressure, the window updates every cycle.
module hex_marquee #(
  parameter int MSG_LEN         = 16,
  parameter int STEP_CYCLES     = 12500000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  input  logic [7*MSG_LEN-1:0]   msg,
  input  logic                   key_run_n,
  input  logic                   key_step_n,
  output logic [6:0]             hex5,
  output logic [6:0]             hex4,
  output logic [6:0]             hex3,
  output logic [6:0]             hex2,
  output logic [6:0]             hex1,
  output logic [6:0]             hex0,
  output logic                   running
);

  localparam int PW = $clog2(MSG_LEN);
  localparam int SW = $clog2(STEP_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] POS_MAX  = PW'(MSG_LEN - 1);
  localparam logic [PW:0]   LEN_W    = (PW+1)'(MSG_LEN);
  localparam logic [SW-1:0] STEP_MAX = SW'(STEP_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {RUN, PAUSE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pos_q;
  logic [SW-1:0] presc_q;
  logic          tick, advance;

  // Index 0 is the run key, index 1 the step key.
  logic [1:0]    raw_n;
  logic [1:0]    sync_1, sync_2, level, press;
  logic [DW-1:0] deb_cnt [2];

  assign raw_n = {key_step_n, key_run_n};

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_1 <= 2'b11;
      sync_2 <= 2'b11;
      level  <= 2'b11;
      press  <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync_1 <= raw_n;
      sync_2 <= sync_1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync_2[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          level[i]   <= sync_2[i];
          deb_cnt[i] <= '0;
          press[i]   <= ~sync_2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign tick = (state_q == RUN) && (presc_q == STEP_MAX);
  // A run press wins over a step press; a tick in RUN always advances.
  assign advance = (state_q == RUN) ? tick : (press[1] && !press[0]);

  always_comb begin
    state_d = state_q;
    if (press[0]) state_d = (state_q == RUN) ? PAUSE : RUN;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= RUN;
      running <= 1'b1;
      presc_q <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      running <= (state_d == RUN);
      if (state_q == RUN) presc_q <= (presc_q == STEP_MAX) ? '0 : presc_q + SW'(1);
      if (advance) pos_q <= (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
    end
  end

  logic [6:0] chars [MSG_LEN];
  logic [6:0] win   [6];
  logic [PW:0] idx_sum;

  always_comb begin
    for (int i = 0; i < MSG_LEN; i++) chars[i] = msg[7*i +: 7];
  end

  always_comb begin
    idx_sum = '0;
    for (int k = 0; k < 6; k++) begin
      idx_sum = {1'b0, pos_q} + (PW+1)'(k);
      if (idx_sum >= LEN_W) idx_sum = idx_sum - LEN_W;
      win[k] = chars[idx_sum[PW-1:0]];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hex5 <= 7'h7F;
      hex4 <= 7'h7F;
      hex3 <= 7'h7F;
      hex2 <= 7'h7F;
      hex1 <= 7'h7F;
      hex0 <= 7'h7F;
    end else begin
      hex5 <= win[0];
      hex4 <= win[1];
      hex3 <= win[2];
      hex2 <= win[3];
      hex1 <= win[4];
      hex0 <= win[5];
    end
  end

endmodule

// File: tb/tb_hex_marquee.sv
// Directed bench for hex_marquee with MSG_LEN=8, STEP_CYCLES=4, DEBOUNCE_CYCLES=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hex_marquee;
  localparam int ML = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [7*ML-1:0]   msg;
  logic              key_run_n, key_step_n;
  logic [6:0]        hex5, hex4, hex3, hex2, hex1, hex0;
  logic              running;

  hex_marquee #(.MSG_LEN(ML), .STEP_CYCLES(4), .DEBOUNCE_CYCLES(3)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .msg(msg),
    .key_run_n(key_run_n), .key_step_n(key_step_n),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .running(running)
  );

  logic [6:0] ch [ML];
  int checks = 0;
  int fails  = 0;
  int t      = 0;   // rising edges since the last reset release

  task automatic go(input int n);
    repeat (n) @(negedge clk);
    t += n;
  endtask

  task automatic upto(input int target);
    go(target - t);
  endtask

  task automatic load_msg();
    for (int i = 0; i < ML; i++) msg[7*i +: 7] = ch[i];
  endtask

  function automatic logic [41:0] win(input int p);
    logic [41:0] r;
    r = '0;
    for (int k = 0; k < 6; k++) r[41-7*k -: 7] = ch[(p+k) % ML];
    return r;
  endfunction

  task automatic chk_hex(input string tag, input logic [41:0] exp);
    logic [41:0] obs;
    obs = {hex5, hex4, hex3, hex2, hex1, hex0};
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: hex observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input int p);
    chk_hex(tag, win(p));
  endtask

  task automatic chk_run(input string tag, input logic exp);
    checks++;
    assert (running === exp) else begin
      fails++;
      $error("FAIL %s: running observed %b expected %b", tag, running, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key_run_n = 1'b1;
    key_step_n = 1'b1;
    for (int i = 0; i < ML; i++) ch[i] = 7'(i);
    load_msg();

    // Reset state and free-running scroll
    repeat (3) @(negedge clk);
    chk_hex("reset_hex", {6{7'h7F}});
    chk_run("reset_running", 1'b1);
    rst_n = 1'b1;
    t = 0;
    go(1);      chk_win("first_window", 0);
    upto(4);    chk_win("before_tick", 0);
    upto(5);    chk_win("tick1", 1);
    upto(9);    chk_win("tick2", 2);
    upto(29);   chk_win("pos7", 7);
    upto(33);   chk_win("wrap", 0);

    // Pause at pos 2, live msg edit, two step presses
    upto(36);   key_run_n = 1'b0;
    upto(42);   key_run_n = 1'b1;
    chk_run("paused", 1'b0);
    chk_win("paused_pos2", 2);
    upto(60);   ch[3] = 7'h2A; load_msg();
    go(1);      chk_win("msg_change", 2);
    ch[3] = 7'h03; load_msg();
    go(1);      chk_win("msg_restore", 2);
    upto(92);   chk_win("frozen", 2);
    chk_run("frozen_running", 1'b0);
    key_step_n = 1'b0;
    upto(96);   key_step_n = 1'b1;
    upto(100);  chk_win("step1", 3);
    upto(104);  key_step_n = 1'b0;
    upto(108);  key_step_n = 1'b1;
    upto(116);  chk_win("step2", 4);

    // Resume: prescaler continues from its frozen count of 2
    key_run_n = 1'b0;
    upto(120);  key_run_n = 1'b1;
    upto(121);  chk_run("resume_latency", 1'b0);
    upto(122);  chk_run("resumed", 1'b1);
    upto(124);  chk_win("resume_hold", 4);
    upto(125);  chk_win("resume_tick", 5);
    upto(129);  chk_win("resume_next", 6);

    // Short glitches and a step press while running
    upto(130);  key_run_n = 1'b0;
    go(1);      key_run_n = 1'b1;
    upto(134);  key_run_n = 1'b0;
    go(2);      key_run_n = 1'b1;
    upto(140);  chk_run("glitch_ignored", 1'b1);
    key_step_n = 1'b0;
    upto(144);  key_step_n = 1'b1;
    upto(150);  chk_win("step_in_run", 3);
    chk_run("step_in_run_state", 1'b1);

    // Simultaneous run and step presses while paused
    upto(152);  key_run_n = 1'b0;
    upto(156);  key_run_n = 1'b1;
    upto(160);  chk_run("pause2", 1'b0);
    chk_win("pause2_pos5", 5);
    upto(170);  key_run_n = 1'b0; key_step_n = 1'b0;
    upto(174);  key_run_n = 1'b1; key_step_n = 1'b1;
    upto(176);  chk_run("both_run", 1'b1);
    upto(177);  chk_win("both_no_step", 5);
    upto(179);  chk_win("both_tick", 6);

    // Reset in the middle of a debounce while paused at pos 5
    upto(202);  key_run_n = 1'b0;
    upto(206);  key_run_n = 1'b1;
    upto(210);  chk_run("pause3", 1'b0);
    chk_win("pause3_pos5", 5);
    upto(214);  key_run_n = 1'b0;
    upto(217);
    rst_n = 1'b0;
    key_run_n = 1'b1;
    #1;
    chk_hex("async_blank", {6{7'h7F}});
    chk_run("async_running", 1'b1);
    go(3);      chk_hex("reset_hold", {6{7'h7F}});
    rst_n = 1'b1;
    t = 0;
    go(1);      chk_win("rerun_first", 0);
    chk_run("rerun_running", 1'b1);
    upto(8);    chk_run("no_spurious_press", 1'b1);
    chk_win("rerun_tick1", 1);
    upto(9);    chk_win("rerun_tick2", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
